// File: rtl/cfu_bank_writer_if.sv
// ---------------------------------------------------------------------------
// cfu_bank_writer_if
//   Bundles the CFU command/response handshake and the four bank write ports
//   of cfu_bank_writer.
//   master : CPU / memory side (drives commands, rsp_ready and bank grants)
//   slave  : the bank writer itself
//   Signals:
//     cmd_valid / cmd_ready           command handshake
//     cmd_payload_function_id [9:0]   [2:0] opcode, rest ignored
//     cmd_payload_inputs_0/1  [31:0]  data / bank select, address
//     rsp_valid / rsp_ready           response handshake
//     rsp_payload_outputs_0   [31:0]  response data
//     port_addr  [N] [13:0]           bank N write address
//     port_wen   [N]                  bank N write request
//     port_wdata [N] [31:0]           bank N write data
//     port_grant [N]                  bank N accepts the write this cycle
// ---------------------------------------------------------------------------
interface cfu_bank_writer_if;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [9:0]       cmd_payload_function_id;
    logic [31:0]      cmd_payload_inputs_0;
    logic [31:0]      cmd_payload_inputs_1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_payload_outputs_0;
    logic [3:0][13:0] port_addr;
    logic [3:0]       port_wen;
    logic [3:0][31:0] port_wdata;
    logic [3:0]       port_grant;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready, port_grant,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0,
               port_addr, port_wen, port_wdata
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, rsp_ready, port_grant,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0,
               port_addr, port_wen, port_wdata
    );
endinterface

// File: rtl/cfu_bank_writer.sv
// ---------------------------------------------------------------------------
// cfu_bank_writer
//   CFU write path into four 14-bit-addressed, 32-bit data banks. Custom
//   instructions set a write pointer and push words into a small write FIFO;
//   the FIFO head is drained into the bank ports, each of which may stall the
//   write until its grant is seen.
//   Ports:
//     clk    clock, all state on rising edge
//     reset  asynchronous, active-low
//     bus    cfu_bank_writer_if.slave (command, response, bank ports)
// ---------------------------------------------------------------------------
module cfu_bank_writer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    cfu_bank_writer_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] OP_SET_PTR   = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_BCAST     = 3'd2;
    localparam logic [2:0] OP_GET_PTR   = 3'd3;
    localparam logic [2:0] OP_GET_COUNT = 3'd4;
    localparam logic [2:0] OP_SYNC      = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_RESP, ST_SYNC_WAIT} state_t;

    state_t        r_state, w_state_next;
    logic [31:0]   r_rsp_data, w_rsp_next;
    logic [1:0]    r_ptr_bank;
    logic [13:0]   r_ptr_addr;
    logic [31:0]   r_wr_count;
    logic [3:0]    r_done;

    logic [3:0]    r_fifo_mask [FIFO_DEPTH];
    logic [13:0]   r_fifo_addr [FIFO_DEPTH];
    logic [31:0]   r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0] r_wr_idx, r_rd_idx;
    logic [AW:0]   r_count;

    logic [2:0]    w_op;
    logic          w_is_push, w_full, w_empty, w_cmd_ready, w_accept, w_push, w_pop;
    logic [3:0]    w_push_mask, w_head_mask, w_wen, w_fire;
    logic [13:0]   w_head_addr;
    logic [31:0]   w_head_data;
    logic [2:0]    w_fire_cnt;
    logic          w_unused_bits;

    assign w_op          = bus.cmd_payload_function_id[2:0];
    assign w_unused_bits = ^{bus.cmd_payload_function_id[9:3], bus.cmd_payload_inputs_1[31:14]};

    assign w_is_push = (w_op == OP_WRITE) || (w_op == OP_BCAST);
    assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);

    // Fullness is the registered state, so a push into a full FIFO waits even
    // if the head pops in the same cycle. Held low while reset is asserted so
    // every output reads 0 during reset.
    assign w_cmd_ready = reset && (r_state == ST_IDLE) && !(w_is_push && w_full);
    assign w_accept    = bus.cmd_valid && w_cmd_ready;
    assign w_push      = w_accept && w_is_push;
    assign w_push_mask = (w_op == OP_BCAST) ? 4'b1111 : (4'b0001 << r_ptr_bank);

    assign w_head_mask = r_fifo_mask[r_rd_idx];
    assign w_head_addr = r_fifo_addr[r_rd_idx];
    assign w_head_data = r_fifo_data[r_rd_idx];

    // A bank keeps requesting until it has been granted once for this head.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            assign w_wen[gi]  = !w_empty && w_head_mask[gi] && !r_done[gi];
            assign w_fire[gi] = w_wen[gi] && bus.port_grant[gi];
        end
    endgenerate

    // Pop once every bank in the mask is either already done or granted now.
    assign w_pop = !w_empty && ((w_head_mask & ~(r_done | w_fire)) == 4'b0000);

    always_comb begin
        w_fire_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            w_fire_cnt = w_fire_cnt + {2'b00, w_fire[i]};
        end
    end

    assign bus.cmd_ready             = w_cmd_ready;
    assign bus.rsp_valid             = (r_state == ST_RESP);
    assign bus.rsp_payload_outputs_0 = r_rsp_data;
    assign bus.port_wen              = w_wen;
    assign bus.port_addr             = w_empty ? '0 : {4{w_head_addr}};
    assign bus.port_wdata            = w_empty ? '0 : {4{w_head_data}};

    always_comb begin
        w_state_next = r_state;
        w_rsp_next   = r_rsp_data;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_op == OP_SYNC) begin
                        w_state_next = ST_SYNC_WAIT;
                    end else begin
                        w_state_next = ST_RESP;
                        case (w_op)
                            OP_WRITE, OP_BCAST: w_rsp_next = {18'b0, r_ptr_addr};
                            OP_GET_PTR:         w_rsp_next = {16'b0, r_ptr_bank, r_ptr_addr};
                            OP_GET_COUNT:       w_rsp_next = r_wr_count;
                            default:            w_rsp_next = '0;
                        endcase
                    end
                end
            end
            ST_SYNC_WAIT: begin
                // Empty FIFO means every queued write has already been counted.
                if (w_empty) begin
                    w_state_next = ST_RESP;
                    w_rsp_next   = r_wr_count;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rsp_data <= '0;
            r_ptr_bank <= '0;
            r_ptr_addr <= '0;
            r_wr_count <= '0;
            r_done     <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_rsp_data <= w_rsp_next;
            r_wr_count <= r_wr_count + {29'b0, w_fire_cnt};
            r_done     <= w_pop ? 4'b0000 : (r_done | w_fire);

            if (w_accept && (w_op == OP_SET_PTR)) begin
                r_ptr_bank <= bus.cmd_payload_inputs_0[1:0];
                r_ptr_addr <= bus.cmd_payload_inputs_1[13:0];
            end else if (w_push) begin
                r_ptr_addr <= r_ptr_addr + 14'd1;
            end

            if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
            if (w_pop)  r_rd_idx <= r_rd_idx + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: it is only visible through a valid head.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mask[r_wr_idx] <= w_push_mask;
            r_fifo_addr[r_wr_idx] <= r_ptr_addr;
            r_fifo_data[r_wr_idx] <= bus.cmd_payload_inputs_0;
        end
    end
endmodule

// File: tb/tb_cfu_bank_writer.sv
module tb_cfu_bank_writer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cfu_bank_writer_if bus_if();

    cfu_bank_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pointer, count of writes issued, and the per-bank
    // sequence of writes each bank must eventually receive.
    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] data;
    } wr_t;

    logic [1:0]  m_bank  = '0;
    logic [13:0] m_addr  = '0;
    logic [31:0] m_count = '0;
    wr_t exp_q [4][$];
    wr_t obs_q [4][$];
    int  wen_cyc [4];
    bit  g_rand = 1'b0;

    logic [3:0] bc_grant [5] = '{4'b0001, 4'b1000, 4'b0000, 4'b0110, 4'b0000};
    logic [3:0] bc_wen   [5] = '{4'b1111, 4'b1110, 4'b0110, 4'b0110, 4'b0000};

    // Log every completed bank write as the memory would see it.
    always @(negedge clk) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_if.port_wen[b]) begin
                    wen_cyc[b]++;
                    if (bus_if.port_grant[b]) obs_q[b].push_back({bus_if.port_addr[b], bus_if.port_wdata[b]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (g_rand) bus_if.port_grant = 4'($urandom);
    endtask

    task automatic model_cmd(input logic [2:0] op, input logic [31:0] in0, input logic [31:0] in1,
                             output logic [31:0] r);
        wr_t e;
        r = '0;
        case (op)
            3'd0: begin
                m_bank = in0[1:0];
                m_addr = in1[13:0];
            end
            3'd1, 3'd2: begin
                e.addr = m_addr;
                e.data = in0;
                if (op == 3'd1) begin
                    exp_q[m_bank].push_back(e);
                    m_count = m_count + 1;
                end else begin
                    for (int b = 0; b < 4; b++) exp_q[b].push_back(e);
                    m_count = m_count + 4;
                end
                r = 32'(m_addr);
                m_addr = 14'((int'(m_addr) + 1) % 16384);
            end
            3'd3:       r = 32'(m_bank) * 32'd16384 + 32'(m_addr);
            3'd4, 3'd5: r = m_count;
            default:    r = '0;
        endcase
    endtask

    // Drive one command through accept and response; reports response and
    // the number of cycles rsp_valid took to appear after acceptance.
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] in0, input logic [31:0] in1,
                          output logic [31:0] rsp, output int lat);
        int n = 0;
        bus_if.cmd_valid               = 1'b1;
        bus_if.cmd_payload_function_id = {7'($urandom), op};
        bus_if.cmd_payload_inputs_0    = in0;
        bus_if.cmd_payload_inputs_1    = in1;
        #1;
        while (!bus_if.cmd_ready && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL accept_timeout op=%0d waited=%0d limit=300", op, n);
        end
        tick();
        bus_if.cmd_valid = 1'b0;
        lat = 0;
        while (!bus_if.rsp_valid && lat < 300) begin
            tick();
            lat++;
        end
        rsp = bus_if.rsp_payload_outputs_0;
        bus_if.rsp_ready = 1'b1;
        tick();
        bus_if.rsp_ready = 1'b0;
        $display("cmd op=%0d in0=%h in1=%h rsp=%h lat=%0d", op, in0, in1, rsp, lat);
    endtask

    task automatic test_reset();
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_payload_function_id = '0;
        bus_if.cmd_payload_inputs_0 = '0;
        bus_if.cmd_payload_inputs_1 = '0;
        bus_if.rsp_ready = 1'b0;
        bus_if.port_grant = 4'b0000;
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({bus_if.cmd_ready, bus_if.rsp_valid, bus_if.port_wen} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl got=%b exp=000000", {bus_if.cmd_ready, bus_if.rsp_valid, bus_if.port_wen});
        end
        total++;
        if (bus_if.port_addr !== '0 || bus_if.port_wdata !== '0 || bus_if.rsp_payload_outputs_0 !== '0) begin
            bad++;
            $display("FAIL reset_data addr=%h wdata=%h rsp=%h exp=0", bus_if.port_addr, bus_if.port_wdata,
                     bus_if.rsp_payload_outputs_0);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus_if.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready got=%b exp=1", bus_if.cmd_ready);
        end
        tick();
    endtask

    task automatic test_single();
        logic [31:0] rsp, exp;
        int lat;
        bus_if.port_grant = 4'b1111;
        do_cmd(3'd0, 32'd2, 32'h0000_0010, rsp, lat);
        model_cmd(3'd0, 32'd2, 32'h0000_0010, exp);
        total++;
        if (rsp !== exp || lat !== 0) begin
            bad++;
            $display("FAIL set_ptr rsp=%h lat=%0d exp_rsp=%h exp_lat=0", rsp, lat, exp);
        end
        for (int b = 0; b < 4; b++) wen_cyc[b] = 0;
        do_cmd(3'd1, 32'hA5A5_A5A5, 32'h0, rsp, lat);
        model_cmd(3'd1, 32'hA5A5_A5A5, 32'h0, exp);
        total++;
        if (rsp !== exp || lat !== 0) begin
            bad++;
            $display("FAIL write_rsp rsp=%h lat=%0d exp_rsp=%h exp_lat=0", rsp, lat, exp);
        end
        tick();
        tick();
        total++;
        if (wen_cyc[2] !== 1 || (wen_cyc[0] + wen_cyc[1] + wen_cyc[3]) !== 0) begin
            bad++;
            $display("FAIL single_wen bank2_cycles=%0d others=%0d exp=1,0", wen_cyc[2],
                     wen_cyc[0] + wen_cyc[1] + wen_cyc[3]);
        end
        do_cmd(3'd3, 32'h0, 32'h0, rsp, lat);
        model_cmd(3'd3, 32'h0, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL get_ptr got=%h exp=%h", rsp, exp);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rsp, exp, d;
        int lat;
        bus_if.port_grant = 4'b1111;
        do_cmd(3'd0, 32'd0, 32'hABCD_3FFF, rsp, lat);
        model_cmd(3'd0, 32'd0, 32'hABCD_3FFF, exp);
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            do_cmd(3'd1, d, 32'h0, rsp, lat);
            model_cmd(3'd1, d, 32'h0, exp);
            total++;
            if (rsp !== exp) begin
                bad++;
                $display("FAIL wrap_write%0d got=%h exp=%h", k, rsp, exp);
            end
        end
        do_cmd(3'd3, 32'h0, 32'h0, rsp, lat);
        model_cmd(3'd3, 32'h0, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL wrap_ptr got=%h exp=%h", rsp, exp);
        end
    endtask

    task automatic test_bcast();
        logic [31:0] rsp, exp;
        int lat;
        bus_if.port_grant = 4'b0000;
        do_cmd(3'd2, 32'hDEAD_BEEF, 32'h0, rsp, lat);
        model_cmd(3'd2, 32'hDEAD_BEEF, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL bcast_rsp got=%h exp=%h", rsp, exp);
        end
        for (int c = 0; c < 5; c++) begin
            bus_if.port_grant = bc_grant[c];
            #1;
            total++;
            if (bus_if.port_wen !== bc_wen[c]) begin
                bad++;
                $display("FAIL bcast_wen cycle=%0d got=%b exp=%b", c + 1, bus_if.port_wen, bc_wen[c]);
            end
            tick();
        end
        bus_if.port_grant = 4'b1111;
        do_cmd(3'd4, 32'h0, 32'h0, rsp, lat);
        model_cmd(3'd4, 32'h0, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL bcast_count got=%0d exp=%0d", rsp, exp);
        end
    endtask

    task automatic test_full();
        logic [31:0] rsp, exp, d;
        int lat;
        bus_if.port_grant = 4'b0000;
        do_cmd(3'd0, 32'd1, 32'h0000_0100, rsp, lat);
        model_cmd(3'd0, 32'd1, 32'h0000_0100, exp);
        for (int k = 0; k < DEPTH; k++) begin
            d = $urandom;
            do_cmd(3'd1, d, 32'h0, rsp, lat);
            model_cmd(3'd1, d, 32'h0, exp);
            total++;
            if (rsp !== exp) begin
                bad++;
                $display("FAIL fill_write%0d got=%h exp=%h", k, rsp, exp);
            end
        end
        // Non-push commands are not blocked by a full FIFO.
        do_cmd(3'd3, 32'h0, 32'h0, rsp, lat);
        model_cmd(3'd3, 32'h0, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL full_get_ptr got=%h exp=%h", rsp, exp);
        end
        d = $urandom;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_payload_function_id = 10'd1;
        bus_if.cmd_payload_inputs_0 = d;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++;
            if (bus_if.cmd_ready !== 1'b0) begin
                bad++;
                $display("FAIL full_ready cycle=%0d got=%b exp=0", c, bus_if.cmd_ready);
            end
            tick();
        end
        bus_if.port_grant = 4'b0010;
        do_cmd(3'd1, d, 32'h0, rsp, lat);
        model_cmd(3'd1, d, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL fifth_write got=%h exp=%h", rsp, exp);
        end
        bus_if.port_grant = 4'b1111;
        do_cmd(3'd5, 32'h0, 32'h0, rsp, lat);
        model_cmd(3'd5, 32'h0, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL full_sync got=%0d exp=%0d", rsp, exp);
        end
    endtask

    task automatic test_sync();
        logic [31:0] rsp, exp, d;
        int lat, n;
        bus_if.port_grant = 4'b0000;
        do_cmd(3'd0, 32'd3, 32'h0000_2000, rsp, lat);
        model_cmd(3'd0, 32'd3, 32'h0000_2000, exp);
        for (int k = 0; k < 3; k++) begin
            d = $urandom;
            do_cmd(3'd1, d, 32'h0, rsp, lat);
            model_cmd(3'd1, d, 32'h0, exp);
        end
        model_cmd(3'd5, 32'h0, 32'h0, exp);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_payload_function_id = 10'd5;
        #1;
        total++;
        if (bus_if.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL sync_ready got=%b exp=1", bus_if.cmd_ready);
        end
        tick();
        bus_if.cmd_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            total++;
            if (bus_if.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL sync_early cycle=%0d rsp_valid=%b exp=0", c, bus_if.rsp_valid);
            end
            tick();
        end
        bus_if.port_grant = 4'b1111;
        n = 0;
        while (!bus_if.rsp_valid && n < 50) begin
            tick();
            n++;
        end
        total++;
        if (n >= 50 || bus_if.port_wen !== 4'b0000) begin
            bad++;
            $display("FAIL sync_resp waited=%0d wen=%b exp=valid_with_wen_0000", n, bus_if.port_wen);
        end
        for (int c = 0; c < 3; c++) begin
            total++;
            if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_payload_outputs_0 !== exp) begin
                bad++;
                $display("FAIL sync_hold cycle=%0d valid=%b got=%0d exp=%0d", c, bus_if.rsp_valid,
                         bus_if.rsp_payload_outputs_0, exp);
            end
            tick();
        end
        bus_if.rsp_ready = 1'b1;
        tick();
        bus_if.rsp_ready = 1'b0;
        total++;
        if (bus_if.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL sync_release rsp_valid=%b exp=0", bus_if.rsp_valid);
        end
        $display("cmd op=5 sync rsp=%0d", exp);
    endtask

    task automatic test_random();
        logic [31:0] rsp, exp, in0, in1;
        logic [2:0] op;
        int lat, k;
        g_rand = 1'b1;
        for (int t = 0; t < 40; t++) begin
            k   = $urandom_range(0, 9);
            in0 = $urandom;
            in1 = $urandom;
            case (k)
                0:          op = 3'd0;
                1, 2, 3, 4: op = 3'd1;
                5, 6:       op = 3'd2;
                7:          op = 3'd3;
                8:          op = 3'd6;
                default:    op = 3'd7;
            endcase
            if (op == 3'd0 && in1[20]) in1[13:0] = 14'h3FFC + 14'($urandom_range(0, 3));
            do_cmd(op, in0, in1, rsp, lat);
            model_cmd(op, in0, in1, exp);
            total++;
            if (rsp !== exp || lat !== 0) begin
                bad++;
                $display("FAIL rand_cmd t=%0d op=%0d got=%h lat=%0d exp=%h exp_lat=0", t, op, rsp, lat, exp);
            end
        end
        do_cmd(3'd5, 32'h0, 32'h0, rsp, lat);
        model_cmd(3'd5, 32'h0, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL rand_sync got=%0d exp=%0d", rsp, exp);
        end
        g_rand = 1'b0;
        bus_if.port_grant = 4'b1111;
        do_cmd(3'd4, 32'h0, 32'h0, rsp, lat);
        model_cmd(3'd4, 32'h0, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL rand_count got=%0d exp=%0d", rsp, exp);
        end
    endtask

    task automatic test_write_log();
        for (int b = 0; b < 4; b++) begin
            total++;
            if (obs_q[b].size() !== exp_q[b].size()) begin
                bad++;
                $display("FAIL log_size bank=%0d got=%0d exp=%0d", b, obs_q[b].size(), exp_q[b].size());
            end else begin
                for (int i = 0; i < exp_q[b].size(); i++) begin
                    total++;
                    if (obs_q[b][i] !== exp_q[b][i]) begin
                        bad++;
                        $display("FAIL log_entry bank=%0d idx=%0d got=%h/%h exp=%h/%h", b, i,
                                 obs_q[b][i].addr, obs_q[b][i].data, exp_q[b][i].addr, exp_q[b][i].data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rsp, exp, d;
        int lat, n;
        bus_if.port_grant = 4'b0000;
        do_cmd(3'd0, 32'd3, 32'h0000_0005, rsp, lat);
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            do_cmd(3'd1, d, 32'h0, rsp, lat);
        end
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (bus_if.port_wen !== 4'b0000 || bus_if.rsp_valid !== 1'b0 || bus_if.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset wen=%b rsp_valid=%b cmd_ready=%b exp=0", bus_if.port_wen,
                     bus_if.rsp_valid, bus_if.cmd_ready);
        end
        m_bank  = '0;
        m_addr  = '0;
        m_count = '0;
        for (int b = 0; b < 4; b++) begin
            exp_q[b].delete();
            obs_q[b].delete();
        end
        tick();
        reset = 1'b1;
        bus_if.port_grant = 4'b1111;
        tick();
        tick();
        n = obs_q[0].size() + obs_q[1].size() + obs_q[2].size() + obs_q[3].size();
        total++;
        if (n !== 0) begin
            bad++;
            $display("FAIL discard writes_after_reset=%0d exp=0", n);
        end
        do_cmd(3'd4, 32'h0, 32'h0, rsp, lat);
        model_cmd(3'd4, 32'h0, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL reset_count got=%0d exp=%0d", rsp, exp);
        end
        do_cmd(3'd3, 32'h0, 32'h0, rsp, lat);
        model_cmd(3'd3, 32'h0, 32'h0, exp);
        total++;
        if (rsp !== exp) begin
            bad++;
            $display("FAIL reset_ptr got=%h exp=%h", rsp, exp);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_bcast();
        test_full();
        test_sync();
        test_random();
        test_write_log();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
